// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_pkg
// Description : Shared types and helpers for the memory controller: FSM state
//               encoding, LSB access-length codes, the default IO region tag
//               and the length-to-last-byte-index helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IFETCH = 2'd1,
        ST_LOAD   = 2'd2,
        ST_STORE  = 2'd3
    } state_t;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd2;

    // addr[17:16] value that selects the IO region
    localparam logic [1:0] IO_HI_BITS_DEFAULT = 2'b11;

    // Index of the last byte of an access (bytes - 1). The illegal code 3
    // is treated as a word.
    function automatic logic [1:0] len_to_last(input logic [1:0] len);
        case (len)
            LEN_B:   return 2'd0;
            LEN_H:   return 2'd1;
            LEN_W:   return 2'd3;
            default: return 2'd3;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Arbitrates instruction fetches and LSB loads/stores onto the
//               byte-wide RAM/IO bus. Each access is split into byte
//               transfers; read results are reassembled little-endian and
//               returned with a one-cycle ready pulse.
// Ports       : clk, rst (async, active-high), rdy (global enable)
//               RAM bus     : mem_din, mem_dout, mem_a, mem_wr, io_buffer_full
//               Fetch side  : ic_ins_asked, ic_ins_addr, ic_enable,
//                             ic_ins_rdy, ic_ins
//               LSB side    : lsb_asked, lsb_wr, lsb_addr, lsb_len,
//                             lsb_signed, lsb_data_in, lsb_rdy, lsb_data_out
//               Flush       : rob_clear
// Options     : MC_LOAD_SIGN_EXT_EN - sign-extend byte/half loads when
//               lsb_signed is set (otherwise all loads zero-extend).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl
    import mc_pkg::*;
#(
    parameter logic [1:0] IO_HI_BITS = IO_HI_BITS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        ic_ins_asked,
    input  logic [31:0] ic_ins_addr,
    output logic        ic_enable,
    output logic        ic_ins_rdy,
    output logic [31:0] ic_ins,
    input  logic        lsb_asked,
    input  logic        lsb_wr,
    input  logic [31:0] lsb_addr,
    input  logic [1:0]  lsb_len,
    input  logic        lsb_signed,
    input  logic [31:0] lsb_data_in,
    output logic        lsb_rdy,
    output logic [31:0] lsb_data_out,
    input  logic        rob_clear
);

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_buf;
    logic [1:0]  r_last;
    // Reads: edges elapsed since accept. Stores: bytes already written.
    logic [2:0]  r_cnt;

    logic        w_fetch_go;
    logic        w_stall_new;
    logic        w_stall;
    logic [1:0]  w_rd_lane;
    logic [7:0]  w_wbyte;
    logic [31:0] w_asm;
    logic [31:0] w_load_result;

    assign w_fetch_go  = ic_ins_asked & ic_enable & ~lsb_asked;
    assign w_stall_new = (lsb_addr[17:16] == IO_HI_BITS) & io_buffer_full;
    assign w_stall     = (r_addr[17:16] == IO_HI_BITS) & io_buffer_full;
    // RAM data trails the address by two edges, so at edge t byte t-2 arrives
    assign w_rd_lane   = r_cnt[1:0] - 2'd2;

    always_comb begin
        case (r_cnt[1:0])
            2'd0:    w_wbyte = r_wdata[7:0];
            2'd1:    w_wbyte = r_wdata[15:8];
            2'd2:    w_wbyte = r_wdata[23:16];
            default: w_wbyte = r_wdata[31:24];
        endcase
    end

    // Final word: collected bytes plus the last byte still on mem_din
    always_comb begin
        w_asm = r_buf;
        case (r_last)
            2'd0:    w_asm[7:0]   = mem_din;
            2'd1:    w_asm[15:8]  = mem_din;
            default: w_asm[31:24] = mem_din;
        endcase
    end

`ifdef MC_LOAD_SIGN_EXT_EN
    logic r_signed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_signed <= 1'b0;
        end else if (rdy && r_state == ST_IDLE && lsb_asked) begin
            r_signed <= lsb_signed;
        end
    end

    always_comb begin
        w_load_result = w_asm;
        if (r_signed && r_last == 2'd0) begin
            w_load_result = {{24{w_asm[7]}}, w_asm[7:0]};
        end else if (r_signed && r_last == 2'd1) begin
            w_load_result = {{16{w_asm[15]}}, w_asm[15:0]};
        end
    end
`else
    logic w_unused_signed;
    assign w_unused_signed = lsb_signed;
    // Unfilled upper bytes are already zero, giving zero extension
    assign w_load_result   = w_asm;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_buf        <= '0;
            r_last       <= 2'd0;
            r_cnt        <= 3'd0;
            mem_dout     <= 8'd0;
            mem_a        <= 32'd0;
            mem_wr       <= 1'b0;
            ic_enable    <= 1'b0;
            ic_ins_rdy   <= 1'b0;
            ic_ins       <= 32'd0;
            lsb_rdy      <= 1'b0;
            lsb_data_out <= 32'd0;
        end else if (!rdy) begin
            // Freeze; a write must not repeat while the bus is halted
            mem_wr <= 1'b0;
        end else begin
            ic_ins_rdy <= 1'b0;
            lsb_rdy    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    mem_wr <= 1'b0;
                    if (lsb_asked) begin
                        r_addr    <= lsb_addr;
                        r_wdata   <= lsb_data_in;
                        r_last    <= len_to_last(lsb_len);
                        r_buf     <= '0;
                        mem_a     <= lsb_addr;
                        ic_enable <= 1'b0;
                        if (lsb_wr) begin
                            r_state <= ST_STORE;
                            if (w_stall_new) begin
                                r_cnt <= 3'd0;
                            end else begin
                                mem_dout <= lsb_data_in[7:0];
                                mem_wr   <= 1'b1;
                                r_cnt    <= 3'd1;
                            end
                        end else begin
                            r_state <= ST_LOAD;
                            r_cnt   <= 3'd1;
                        end
                    end else if (w_fetch_go) begin
                        r_state   <= ST_IFETCH;
                        r_addr    <= ic_ins_addr;
                        r_last    <= 2'd3;
                        r_buf     <= '0;
                        mem_a     <= ic_ins_addr;
                        r_cnt     <= 3'd1;
                        ic_enable <= 1'b0;
                    end else begin
                        ic_enable <= 1'b1;
                    end
                end

                ST_IFETCH, ST_LOAD: begin
                    if (rob_clear) begin
                        r_state   <= ST_IDLE;
                        ic_enable <= 1'b1;
                    end else begin
                        if (r_cnt <= {1'b0, r_last}) begin
                            mem_a <= r_addr + {29'd0, r_cnt};
                        end
                        if (r_cnt == {1'b0, r_last} + 3'd2) begin
                            if (r_state == ST_IFETCH) begin
                                ic_ins     <= w_asm;
                                ic_ins_rdy <= 1'b1;
                            end else begin
                                lsb_data_out <= w_load_result;
                                lsb_rdy      <= 1'b1;
                            end
                            r_state   <= ST_IDLE;
                            ic_enable <= 1'b1;
                        end else begin
                            if (r_cnt >= 3'd2) begin
                                case (w_rd_lane)
                                    2'd0:    r_buf[7:0]   <= mem_din;
                                    2'd1:    r_buf[15:8]  <= mem_din;
                                    2'd2:    r_buf[23:16] <= mem_din;
                                    default: r_buf[31:24] <= mem_din;
                                endcase
                            end
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                end

                ST_STORE: begin
                    // Stores are post-commit, so rob_clear does not apply
                    if (r_cnt > {1'b0, r_last}) begin
                        lsb_rdy   <= 1'b1;
                        mem_wr    <= 1'b0;
                        r_state   <= ST_IDLE;
                        ic_enable <= 1'b1;
                    end else if (w_stall) begin
                        mem_wr <= 1'b0;
                    end else begin
                        mem_a    <= r_addr + {29'd0, r_cnt};
                        mem_dout <= w_wbyte;
                        mem_wr   <= 1'b1;
                        r_cnt    <= r_cnt + 3'd1;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Self-checking bench for mem_ctrl. A byte-addressed RAM model
//               (gated by rdy) serves the bus; a shadow memory plus
//               plain-arithmetic expectations give every expected value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    localparam int AW = 18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b0;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;
    logic        ic_ins_asked = 1'b0;
    logic [31:0] ic_ins_addr = 32'd0;
    logic        ic_enable;
    logic        ic_ins_rdy;
    logic [31:0] ic_ins;
    logic        lsb_asked = 1'b0;
    logic        lsb_wr = 1'b0;
    logic [31:0] lsb_addr = 32'd0;
    logic [1:0]  lsb_len = 2'd0;
    logic        lsb_signed = 1'b0;
    logic [31:0] lsb_data_in = 32'd0;
    logic        lsb_rdy;
    logic [31:0] lsb_data_out;
    logic        rob_clear = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ram    [0:(1<<AW)-1];
    logic [7:0]  shadow [0:(1<<AW)-1];
    logic [39:0] wlog[$];
    logic [31:0] qa[$];
    logic        en_after_accept;
    logic        en_after_clr;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full),
        .ic_ins_asked   (ic_ins_asked),
        .ic_ins_addr    (ic_ins_addr),
        .ic_enable      (ic_enable),
        .ic_ins_rdy     (ic_ins_rdy),
        .ic_ins         (ic_ins),
        .lsb_asked      (lsb_asked),
        .lsb_wr         (lsb_wr),
        .lsb_addr       (lsb_addr),
        .lsb_len        (lsb_len),
        .lsb_signed     (lsb_signed),
        .lsb_data_in    (lsb_data_in),
        .lsb_rdy        (lsb_rdy),
        .lsb_data_out   (lsb_data_out),
        .rob_clear      (rob_clear)
    );

    // RAM model: samples mem_a at a clock edge, data valid one cycle later
    always @(posedge clk) begin
        if (rdy && !rst) begin
            if (mem_wr) begin
                ram[mem_a[AW-1:0]] <= mem_dout;
                wlog.push_back({mem_a, mem_dout});
            end
            mem_din <= ram[mem_a[AW-1:0]];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int nbytes(input logic [1:0] len);
        return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    endfunction

    // Expected load value from the shadow memory
    function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] len, input bit sg);
        logic [31:0] v;
        logic [31:0] t;
        int          nb;
        nb = nbytes(len);
        v  = 32'd0;
        for (int k = 0; k < nb; k++) begin
            t = a + 32'(k);
            v = v | (32'(shadow[t[AW-1:0]]) << (8 * k));
        end
`ifdef MC_LOAD_SIGN_EXT_EN
        if (sg && nb == 1 && v[7])  v = v | 32'hFFFFFF00;
        if (sg && nb == 2 && v[15]) v = v | 32'hFFFF0000;
`else
        if (sg) v = v;
`endif
        return v;
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ic_enable) break;
        end
    endtask

    // Issues one fetch/load and reports result, latency (edges after the
    // accept edge until the pulse is registered) and the mem_a trace.
    task automatic run_read(input bit fetch, input logic [31:0] a, input logic [1:0] len,
                            input bit sg, input int freeze_at, input int clr_at,
                            output logic [31:0] data, output int lat);
        lat  = -1;
        data = 32'd0;
        wait_idle();
        if (fetch) begin
            ic_ins_asked = 1'b1;
            ic_ins_addr  = a;
        end else begin
            lsb_asked  = 1'b1;
            lsb_wr     = 1'b0;
            lsb_addr   = a;
            lsb_len    = len;
            lsb_signed = sg;
        end
        @(posedge clk);
        @(negedge clk);
        ic_ins_asked    = 1'b0;
        lsb_asked       = 1'b0;
        en_after_accept = ic_enable;
        qa.delete();
        qa.push_back(mem_a);
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc == clr_at + 1) en_after_clr = ic_enable;
            if (fetch ? ic_ins_rdy : lsb_rdy) begin
                data = fetch ? ic_ins : lsb_data_out;
                lat  = cyc;
                break;
            end
            if (cyc == freeze_at)     rdy = 1'b0;
            if (cyc == freeze_at + 2) rdy = 1'b1;
            rob_clear = (cyc == clr_at);
            @(posedge clk);
            @(negedge clk);
            qa.push_back(mem_a);
        end
        rdy       = 1'b1;
        rob_clear = 1'b0;
    endtask

    // io_mode: 0 = never full, 1 = random, 2 = full for the first 3 edges
    task automatic run_store(input logic [31:0] a, input logic [1:0] len, input logic [31:0] d,
                             input int io_mode, input bit rob,
                             output int lat, output int viol);
        lat  = -1;
        viol = 0;
        wait_idle();
        wlog.delete();
        lsb_asked   = 1'b1;
        lsb_wr      = 1'b1;
        lsb_addr    = a;
        lsb_len     = len;
        lsb_data_in = d;
        rob_clear   = rob;
        io_buffer_full = (io_mode == 2) ? 1'b1 : (io_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk);
        @(negedge clk);
        lsb_asked = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (lsb_rdy) begin
                lat = cyc;
                break;
            end
            if (io_mode == 2) begin
                if (cyc <= 2 && mem_wr) viol++;
                if (cyc == 2) io_buffer_full = 1'b0;
            end else if (io_mode == 1) begin
                io_buffer_full = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            @(negedge clk);
        end
        io_buffer_full = 1'b0;
        rob_clear      = 1'b0;
    endtask

    // Write log must be exactly the bytes of d at a, a+1, ... in order
    function automatic bit log_ok(input logic [31:0] a, input logic [1:0] len, input logic [31:0] d);
        int nb;
        nb = nbytes(len);
        if (wlog.size() != nb) return 1'b0;
        for (int k = 0; k < nb; k++) begin
            if (wlog[k] !== {a + 32'(k), d[8*k +: 8]}) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic shadow_store(input logic [31:0] a, input logic [1:0] len, input logic [31:0] d);
        logic [31:0] t;
        for (int k = 0; k < nbytes(len); k++) begin
            t = a + 32'(k);
            shadow[t[AW-1:0]] = d[8*k +: 8];
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({mem_wr, ic_enable, ic_ins_rdy, lsb_rdy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000", {mem_wr, ic_enable, ic_ins_rdy, lsb_rdy});
        end
        checks++;
        if ({mem_a, ic_ins, lsb_data_out, mem_dout} !== 104'd0) begin
            errors++;
            $display("FAIL reset_data: mem_a=%h ic_ins=%h lsb=%h dout=%h required all 0",
                     mem_a, ic_ins, lsb_data_out, mem_dout);
        end
        rst = 1'b0;
        rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (ic_enable !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_enable: got %b required 1", ic_enable);
        end
    endtask

    task automatic test_word_fetch();
        logic [31:0] d;
        int          lat;
        bit          ok;
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h10; ram[32'h103] = 8'h00;
        shadow[32'h100] = 8'h13; shadow[32'h101] = 8'h05; shadow[32'h102] = 8'h10; shadow[32'h103] = 8'h00;
        run_read(1'b1, 32'h100, 2'd2, 1'b0, -1, -1, d, lat);
        checks++;
        if (en_after_accept !== 1'b0) begin
            errors++;
            $display("FAIL fetch_enable_drop: got %b required 0", en_after_accept);
        end
        checks++;
        if (lat != 5 || d !== 32'h00100513) begin
            errors++;
            $display("FAIL fetch_word: latency %0d data %h required 5 00100513", lat, d);
        end
        ok = (qa.size() >= 6);
        for (int k = 0; k < 6 && ok; k++) ok = (qa[k] === 32'h100 + 32'((k > 3) ? 3 : k));
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL fetch_addr_seq: got %p required 100,101,102,103,103,103", qa);
        end
        checks++;
        if (ic_enable !== 1'b1) begin
            errors++;
            $display("FAIL fetch_enable_back: got %b required 1", ic_enable);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] exp;
        bit          early = 1'b0;
        bit          got   = 1'b0;
        int          lat   = -1;
        ram[32'h200] = 8'h80;
        shadow[32'h200] = 8'h80;
        exp = exp_load(32'h200, 2'd0, 1'b1);
        wait_idle();
        lsb_asked = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h200; lsb_len = 2'd0; lsb_signed = 1'b1;
        ic_ins_asked = 1'b1; ic_ins_addr = 32'h0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (ic_ins_rdy) early = 1'b1;
            if (lsb_rdy) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got || lsb_data_out !== exp || early) begin
            errors++;
            $display("FAIL simul_load_first: got=%b data %h early_fetch=%b required 1 %h 0",
                     got, lsb_data_out, early, exp);
        end
        checks++;
        if (ic_enable !== 1'b1) begin
            errors++;
            $display("FAIL simul_enable: got %b required 1", ic_enable);
        end
        lsb_asked = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ic_enable !== 1'b0) begin
            errors++;
            $display("FAIL simul_fetch_accept: ic_enable %b required 0", ic_enable);
        end
        ic_ins_asked = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (ic_ins_rdy) begin
                lat = cyc;
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (lat != 5 || ic_ins !== exp_load(32'h0, 2'd2, 1'b0)) begin
            errors++;
            $display("FAIL simul_fetch: latency %0d data %h required 5 %h", lat, ic_ins, exp_load(32'h0, 2'd2, 1'b0));
        end
    endtask

    task automatic test_io_stall();
        int lat;
        int viol;
        bit pulse_long;
        run_store(32'h30000, 2'd1, 32'h0000BEEF, 2, 1'b0, lat, viol);
        @(negedge clk);
        pulse_long = lsb_rdy;
        shadow_store(32'h30000, 2'd1, 32'h0000BEEF);
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL io_stall_wr: mem_wr high on %0d stall cycles required 0", viol);
        end
        checks++;
        if (!log_ok(32'h30000, 2'd1, 32'h0000BEEF)) begin
            errors++;
            $display("FAIL io_store_log: got %p required {00030000ef,00030001be}", wlog);
        end
        checks++;
        if (lat != 5 || pulse_long) begin
            errors++;
            $display("FAIL io_store_pulse: latency %0d long=%b required 5 0", lat, pulse_long);
        end
    endtask

    task automatic test_rdy_freeze();
        logic [31:0] d;
        int          lat;
        wlog.delete();
        run_read(1'b0, 32'h2345, 2'd2, 1'b0, 2, -1, d, lat);
        checks++;
        if (lat != 7 || d !== exp_load(32'h2345, 2'd2, 1'b0)) begin
            errors++;
            $display("FAIL freeze_load: latency %0d data %h required 7 %h", lat, d, exp_load(32'h2345, 2'd2, 1'b0));
        end
        checks++;
        if (wlog.size() != 0) begin
            errors++;
            $display("FAIL freeze_no_write: %0d writes required 0", wlog.size());
        end
    endtask

    task automatic test_rob_clear();
        logic [31:0] d;
        int          lat;
        int          viol;
        run_read(1'b1, 32'h400, 2'd2, 1'b0, -1, 1, d, lat);
        checks++;
        if (lat != -1) begin
            errors++;
            $display("FAIL rob_fetch_abort: pulse after %0d edges required none", lat);
        end
        checks++;
        if (en_after_clr !== 1'b1) begin
            errors++;
            $display("FAIL rob_fetch_idle: ic_enable %b required 1", en_after_clr);
        end
        run_store(32'h500, 2'd2, 32'hCAFEF00D, 0, 1'b1, lat, viol);
        shadow_store(32'h500, 2'd2, 32'hCAFEF00D);
        checks++;
        if (lat != 4 || !log_ok(32'h500, 2'd2, 32'hCAFEF00D)) begin
            errors++;
            $display("FAIL rob_store_completes: latency %0d log %p required 4 and 4 bytes", lat, wlog);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        int          lat;
        wait_idle();
        lsb_asked = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h1000; lsb_len = 2'd2; lsb_data_in = 32'h44332211;
        @(posedge clk);
        @(negedge clk);
        lsb_asked = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_wr !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre_wr: mem_wr %b required 1", mem_wr);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({mem_wr, ic_enable, ic_ins_rdy, lsb_rdy} !== 4'b0000) begin
            errors++;
            $display("FAIL arst_clear: got %b required 0000", {mem_wr, ic_enable, ic_ins_rdy, lsb_rdy});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ic_enable !== 1'b1 || mem_wr !== 1'b0 || lsb_rdy !== 1'b0) begin
            errors++;
            $display("FAIL arst_idle: en %b wr %b rdy %b required 1 0 0", ic_enable, mem_wr, lsb_rdy);
        end
        // Only byte 0 reached the RAM before reset
        shadow[32'h1000] = 8'h11;
        run_read(1'b0, 32'h1000, 2'd2, 1'b0, -1, -1, d, lat);
        checks++;
        if (lat != 5 || d !== exp_load(32'h1000, 2'd2, 1'b0)) begin
            errors++;
            $display("FAIL arst_partial: latency %0d data %h required 5 %h", lat, d, exp_load(32'h1000, 2'd2, 1'b0));
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        logic [1:0]  len;
        bit          sg;
        bit          ok;
        int          op;
        int          n;
        int          lat;
        int          viol;
        for (int i = 0; i < 30; i++) begin
            op  = (i == 0) ? 0 : int'($urandom_range(0, 2));
            a   = (i == 0) ? 32'hFFFFFFFE : $urandom;
            len = 2'($urandom_range(0, 3));
            sg  = 1'($urandom_range(0, 1));
            d   = $urandom;
            if (op == 2) begin
                run_store(a, len, d, 1, 1'b0, lat, viol);
                shadow_store(a, len, d);
                checks++;
                if (lat < 0 || !log_ok(a, len, d)) begin
                    errors++;
                    $display("FAIL rand_store[%0d]: addr %h len %0d data %h latency %0d log %p",
                             i, a, len, d, lat, wlog);
                end
            end else begin
                if (op == 0) len = 2'd2;
                n   = nbytes(len) - 1;
                exp = exp_load(a, len, (op == 1) ? sg : 1'b0);
                run_read(op == 0, a, len, sg, -1, -1, d, lat);
                ok = (lat == n + 2) && (qa.size() >= n + 3);
                for (int k = 0; k <= n + 2 && ok; k++) ok = (qa[k] === a + 32'((k > n) ? n : k));
                checks++;
                if (!ok || d !== exp) begin
                    errors++;
                    $display("FAIL rand_read[%0d]: op %0d addr %h len %0d latency %0d data %h required %0d %h",
                             i, op, a, len, lat, d, n + 2, exp);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]    = 8'($urandom);
            shadow[i] = ram[i];
        end
        test_reset();
        test_word_fetch();
        test_simultaneous();
        test_io_stall();
        test_rdy_freeze();
        test_rob_clear();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
